// File: rtl/perf_counter_sampler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : perf_counter_sampler_pkg
// Purpose  : Shared types, CSR addresses and mask helpers for the
//            performance-counter sampler.
// Revision : 1.0 - initial release
// ============================================================================
package perf_counter_sampler_pkg;

  localparam int XLEN           = 64;
  localparam int PERF_SEQ_WIDTH = 16;

  // Machine hardware performance counter CSR addresses (low and high halves)
  localparam logic [11:0] CSR_MHPM_COUNTER_3  = 12'hB03;
  localparam logic [11:0] CSR_MHPM_COUNTER_3H = 12'hB83;

  typedef struct packed {
    logic [PERF_SEQ_WIDTH-1:0] seq;
    logic [2:0]                idx;
    logic                      last;
    logic [63:0]               value;
  } perf_sample_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_READ_LO = 3'd2,
    S_READ_HI = 3'd3,
    S_CLEAR   = 3'd4,
    S_PUSH    = 3'd5,
    S_DONE    = 3'd6
  } sampler_state_e;

  // Lowest set bit of mask at position >= from; returns 8 when there is none
  function automatic logic [3:0] next_set(input logic [7:0] mask, input logic [3:0] from);
    logic [3:0] r;
    r = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) r = 4'(i);
    end
    return r;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] mask);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, mask[i]};
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/perf_counter_sampler_if.sv
`default_nettype none
// ============================================================================
// Module   : perf_counter_sampler_if
// Purpose  : Counter-port (req/gnt CSR access) and snapshot stream bundle.
//            master = sampler side, slave = counter bank / consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface perf_counter_sampler_if #(
  parameter int XLEN = 64
);
  import perf_counter_sampler_pkg::*;

  logic            req;
  logic            gnt;
  logic [11:0]     addr;
  logic            we;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;

  logic            sample_valid;
  logic            sample_ready;
  perf_sample_t    sample;

  modport master (
    output req, addr, we, wdata, sample_valid, sample,
    input  gnt, rdata, sample_ready
  );

  modport slave (
    input  req, addr, we, wdata, sample_valid, sample,
    output gnt, rdata, sample_ready
  );

endinterface
`default_nettype wire

// File: rtl/perf_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : perf_sample_fifo
// Purpose  : Synchronous FIFO with register-array head and free-count output.
//            A push into a full FIFO is accepted when a pop happens alongside.
// Revision : 1.0 - initial release
// ============================================================================
module perf_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  wire logic                       clk_i,
  input  wire logic                       rst_i,
  input  wire logic                       i_push,
  input  wire logic [WIDTH-1:0]           i_data,
  input  wire logic                       i_pop,
  output logic                            o_valid,
  output logic [WIDTH-1:0]                o_data,
  output logic [$clog2(DEPTH):0]          o_free
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = i_pop && (r_cnt != '0);
  assign w_push = i_push && ((r_cnt != CW'(DEPTH)) || w_pop);

  // Storage array; cleared on reset so the head reads zero when empty
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_valid = (r_cnt != '0);
  assign o_data  = r_mem[r_rd];
  assign o_free  = CW'(DEPTH) - r_cnt;

endmodule
`default_nettype wire

// File: rtl/perf_counter_sampler.sv
`default_nettype none
// ============================================================================
// Module   : perf_counter_sampler
// Purpose  : Walks the selected mhpmcounters on a timer tick or software
//            trigger, optionally clears them, and streams snapshots out.
// Revision : 1.0 - initial release
// ============================================================================
module perf_counter_sampler
  import perf_counter_sampler_pkg::*;
#(
  parameter int NUM_COUNTERS   = 6,
  parameter int FIFO_DEPTH     = 8,
  parameter int INTERVAL_WIDTH = 32,
  parameter int XLEN           = perf_counter_sampler_pkg::XLEN
) (
  input  wire logic                      clk_i,
  input  wire logic                      rst_i,
  input  wire logic                      enable_i,
  input  wire logic [INTERVAL_WIDTH-1:0] interval_i,
  input  wire logic                      trigger_i,
  input  wire logic [NUM_COUNTERS-1:0]   counter_mask_i,
  input  wire logic                      clear_on_read_i,
  input  wire logic                      debug_mode_i,
  output logic                           busy_o,
  output logic [15:0]                    drop_cnt_o,
  perf_counter_sampler_if.master         bus
);
  localparam int  CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam bit  IS32  = (XLEN == 32);

  sampler_state_e            r_state;
  sampler_state_e            w_next;
  logic [INTERVAL_WIDTH-1:0] r_timer;
  logic                      r_pending;
  logic                      r_clr_hi;
  logic [7:0]                r_mask;
  logic [2:0]                r_idx;
  logic [63:0]               r_value;
  logic [PERF_SEQ_WIDTH-1:0] r_seq;
  logic [15:0]               r_drop;

  logic [7:0]                w_mask_in;
  logic [3:0]                w_n;
  logic [2:0]                w_first;
  logic [3:0]                w_next_idx;
  logic                      w_last;
  logic                      w_fits;
  logic [CNT_W-1:0]          w_free;
  logic                      w_tmr_run;
  logic                      w_tmr_fire;
  logic                      w_pend_clr;
  logic                      w_push;
  logic                      w_req;
  logic                      w_addr_hi;
  logic [63:0]               w_rdata64;
  logic [$bits(perf_sample_t)-1:0] w_push_data;
  logic [$bits(perf_sample_t)-1:0] w_head;

  assign w_mask_in  = 8'(counter_mask_i);
  assign w_n        = popcount8(w_mask_in);
  assign w_first    = 3'(next_set(w_mask_in, 4'd0));
  assign w_next_idx = next_set(r_mask, {1'b0, r_idx} + 4'd1);
  assign w_last     = w_next_idx[3];
  assign w_fits     = int'(w_free) >= int'(w_n);

  // Read data widened to 64 bits so both halves use the same capture path
  if (XLEN == 32) begin : g_rd32
    assign w_rdata64 = {32'b0, bus.rdata};
  end else begin : g_rd64
    assign w_rdata64 = bus.rdata[63:0];
  end

  assign w_tmr_run  = enable_i && (interval_i != '0) && !debug_mode_i;
  assign w_tmr_fire = w_tmr_run && (r_timer == interval_i - 1'b1);

  // Interval timer; an out-of-range value after an interval change wraps silently
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_timer <= '0;
    end else if (w_tmr_run) begin
      if (r_timer >= interval_i - 1'b1) r_timer <= '0;
      else                              r_timer <= r_timer + 1'b1;
    end
  end

  // One-deep request flag; a new event in the CHECK cycle survives the clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_pending <= 1'b0;
    else       r_pending <= trigger_i || w_tmr_fire || (r_pending && !w_pend_clr);
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next state and strobes; debug mode freezes everything in place
  always_comb begin
    w_next     = r_state;
    w_req      = 1'b0;
    w_pend_clr = 1'b0;
    w_push     = 1'b0;
    if (!debug_mode_i) begin
      case (r_state)
        S_IDLE:    if (r_pending) w_next = S_CHECK;
        S_CHECK: begin
          w_pend_clr = 1'b1;
          w_next     = ((w_n == 4'd0) || !w_fits) ? S_IDLE : S_READ_LO;
        end
        S_READ_LO: begin
          w_req = 1'b1;
          if (bus.gnt) begin
            if (IS32)                 w_next = S_READ_HI;
            else if (clear_on_read_i) w_next = S_CLEAR;
            else                      w_next = S_PUSH;
          end
        end
        S_READ_HI: begin
          w_req = 1'b1;
          if (bus.gnt) w_next = clear_on_read_i ? S_CLEAR : S_PUSH;
        end
        S_CLEAR: begin
          w_req = 1'b1;
          if (bus.gnt && (!IS32 || r_clr_hi)) w_next = S_PUSH;
        end
        S_PUSH: begin
          w_push = 1'b1;
          w_next = w_last ? S_DONE : S_READ_LO;
        end
        S_DONE:    w_next = S_IDLE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // Walk datapath: mask/index, captured value, sequence and drop counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mask   <= '0;
      r_idx    <= '0;
      r_value  <= '0;
      r_seq    <= '0;
      r_drop   <= '0;
      r_clr_hi <= 1'b0;
    end else if (!debug_mode_i) begin
      case (r_state)
        S_CHECK: begin
          r_mask   <= w_mask_in;
          r_idx    <= w_first;
          r_clr_hi <= 1'b0;
          if ((w_n != 4'd0) && !w_fits && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
        end
        S_READ_LO: if (bus.gnt) r_value <= IS32 ? {r_value[63:32], w_rdata64[31:0]} : w_rdata64;
        S_READ_HI: if (bus.gnt) r_value[63:32] <= w_rdata64[31:0];
        S_CLEAR:   if (bus.gnt && IS32 && !r_clr_hi) r_clr_hi <= 1'b1;
        S_PUSH: begin
          r_idx    <= w_next_idx[2:0];
          r_clr_hi <= 1'b0;
        end
        S_DONE:    r_seq <= r_seq + 1'b1;
        default: ;
      endcase
    end
  end

  assign w_push_data = {r_seq, r_idx, w_last, r_value};

  perf_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(perf_sample_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (bus.sample_valid && bus.sample_ready),
    .o_valid (bus.sample_valid),
    .o_data  (w_head),
    .o_free  (w_free)
  );

  assign w_addr_hi  = (r_state == S_READ_HI) || ((r_state == S_CLEAR) && r_clr_hi);
  assign bus.req    = w_req;
  assign bus.we     = w_req && (r_state == S_CLEAR);
  assign bus.addr   = w_req ? ((w_addr_hi ? CSR_MHPM_COUNTER_3H : CSR_MHPM_COUNTER_3) + {9'b0, r_idx})
                            : 12'h000;
  assign bus.wdata  = '0;
  assign bus.sample = perf_sample_t'(w_head);
  assign busy_o     = (r_state != S_IDLE);
  assign drop_cnt_o = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_perf_counter_sampler
// Purpose  : Scoreboard bench for perf_counter_sampler (64-bit instance plus
//            a small 32-bit instance for the split high/low read).
// Revision : 1.0 - initial release
// ============================================================================
module tb_perf_counter_sampler;
  import perf_counter_sampler_pkg::*;

  localparam int NC    = 6;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, trigger, clear_on_read, debug_mode, trig32;
  logic [31:0] interval;
  logic [5:0]  mask;
  logic        busy, busy32;
  logic [15:0] drop, drop32;

  perf_counter_sampler_if #(.XLEN(64)) bus ();
  perf_counter_sampler_if #(.XLEN(32)) if32 ();

  perf_counter_sampler #(.NUM_COUNTERS(NC), .FIFO_DEPTH(DEPTH), .INTERVAL_WIDTH(32), .XLEN(64)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .interval_i(interval), .trigger_i(trigger),
    .counter_mask_i(mask), .clear_on_read_i(clear_on_read), .debug_mode_i(debug_mode),
    .busy_o(busy), .drop_cnt_o(drop), .bus(bus));

  perf_counter_sampler #(.NUM_COUNTERS(NC), .FIFO_DEPTH(DEPTH), .INTERVAL_WIDTH(32), .XLEN(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .enable_i(1'b0), .interval_i(32'd0), .trigger_i(trig32),
    .counter_mask_i(6'b000001), .clear_on_read_i(1'b0), .debug_mode_i(1'b0),
    .busy_o(busy32), .drop_cnt_o(drop32), .bus(if32));

  // ---------------- counter bank responder ----------------
  logic [63:0] bank [NC];
  logic [63:0] load_val [NC];
  logic        load_en;
  logic [2:0]  bidx;
  logic        in_rng;
  assign bidx      = 3'(bus.addr - 12'hB03);
  assign in_rng    = (bus.addr >= 12'hB03) && (bus.addr < 12'hB09);
  assign bus.rdata = in_rng ? bank[bidx] : 64'hDEAD_BEEF_DEAD_BEEF;

  always @(posedge clk) begin
    if (load_en) begin
      for (int k = 0; k < NC; k++) bank[k] <= load_val[k];
    end else if (bus.req && bus.gnt && bus.we && in_rng) begin
      bank[bidx] <= 64'd0;
    end
  end

  assign if32.rdata = (if32.addr == 12'hB03) ? 32'h0000_0002 :
                      (if32.addr == 12'hB83) ? 32'h0000_0001 : 32'hBAD0_BAD0;
  assign if32.gnt          = 1'b1;
  assign if32.sample_ready = 1'b1;

  // gnt/ready pattern: 0 = held low, 1 = held high, 2 = random per cycle
  int gnt_mode, rdy_mode;
  initial begin
    bus.gnt = 1'b0; bus.sample_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.gnt          = (gnt_mode == 2) ? 1'($urandom_range(0, 3) != 0) : (gnt_mode == 1);
      bus.sample_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1))      : (rdy_mode == 1);
    end
  end

  // ---------------- scoreboard / reference model ----------------
  perf_sample_t exp_q[$];
  logic [11:0]  addr32_q[$];
  logic [63:0]  model_bank [NC];
  int           model_seq, exp_drop;
  int           checks, errors;
  int           acc_cnt, we_cnt;

  // Monitor: compares every accepted snapshot and every counter write
  initial begin
    perf_sample_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.sample_valid && bus.sample_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sample_unexpected got=%h required=none", bus.sample);
          end else begin
            e = exp_q.pop_front();
            if (bus.sample !== e) begin
              errors++;
              $display("FAIL sample got=%h required=%h", bus.sample, e);
            end
          end
        end
        if (bus.req && bus.gnt) acc_cnt++;
        if (bus.req && bus.gnt && bus.we) begin
          we_cnt++;
          checks++;
          if (bus.wdata !== 64'd0) begin
            errors++;
            $display("FAIL clear_wdata got=%h required=0", bus.wdata);
          end
        end
        if (if32.req && if32.gnt) addr32_q.push_back(if32.addr);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Snapshot rules applied to the model bank at request time
  task automatic model_snapshot(input logic [5:0] m, input logic c);
    perf_sample_t s;
    int n, hi;
    n = $countones(m);
    hi = -1;
    if (n == 0) return;
    if (DEPTH - exp_q.size() < n) begin
      exp_drop++;
      return;
    end
    for (int k = 0; k < NC; k++) if (m[k]) hi = k;
    for (int k = 0; k < NC; k++) begin
      if (m[k]) begin
        s.seq   = 16'(model_seq);
        s.idx   = 3'(k);
        s.last  = (k == hi);
        s.value = model_bank[k];
        exp_q.push_back(s);
        if (c) model_bank[k] = 64'd0;
      end
    end
    model_seq++;
  endtask

  task automatic load_bank(input bit rnd, input logic [63:0] v0, input logic [63:0] v2);
    for (int k = 0; k < NC; k++) begin
      load_val[k] = rnd ? {$urandom, $urandom} : 64'(100 + k);
      if (!rnd && k == 0) load_val[k] = v0;
      if (!rnd && k == 2) load_val[k] = v2;
      model_bank[k] = load_val[k];
    end
    load_en = 1'b1; tick(); load_en = 1'b0; tick();
  endtask

  task automatic trig_only(input logic [5:0] m, input logic c);
    mask = m; clear_on_read = c;
    model_snapshot(m, c);
    trigger = 1'b1; tick(); trigger = 1'b0;
  endtask

  // Waits for a walk to start and finish; returns cycles spent busy
  task automatic wait_idle(output int bcyc);
    int t;
    bcyc = 0; t = 0;
    while (!busy && t < 8) begin tick(); t++; end
    t = 0;
    while (busy && t < 600) begin bcyc++; tick(); t++; end
    if (t == 0 || t >= 600) begin
      checks++; errors++;
      $display("FAIL walk_timeout got=%0d required=walk", t);
    end
  endtask

  task automatic wait_room();
    int t = 0;
    while (exp_q.size() > DEPTH - NC && t < 500) begin tick(); t++; end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin tick(); t++; end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic bank_match();
    for (int k = 0; k < NC; k++) check("bank_after_walk", bank[k], model_bank[k]);
  endtask

  initial begin
    int bc, prev_rise, cyc, rises, acc0, we0;
    bit bad, pbusy;
    perf_sample_t s32;
    rst = 1'b1; enable = 0; trigger = 0; trig32 = 0; clear_on_read = 0; debug_mode = 0;
    interval = 0; mask = 0; load_en = 0; gnt_mode = 1; rdy_mode = 1;
    checks = 0; errors = 0; model_seq = 0; exp_drop = 0; acc_cnt = 0; we_cnt = 0;
    for (int k = 0; k < NC; k++) load_val[k] = 64'd0;
    repeat (3) tick();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_req", 64'(bus.req), 64'd0);
    check("reset_valid", 64'(bus.sample_valid), 64'd0);
    check("reset_drop", 64'(drop), 64'd0);
    check("reset_addr", 64'(bus.addr), 64'd0);
    check("reset_sample", 64'(bus.sample[63:0]), 64'd0);
    rst = 1'b0; tick();

    // 32-bit build: split high/low read of 0x1_0000_0002
    trig32 = 1'b1; tick(); trig32 = 1'b0;
    bc = 0;
    while (!if32.sample_valid && bc < 30) begin tick(); bc++; end
    s32 = if32.sample;
    check("x32_value", s32.value, 64'h1_0000_0002);
    check("x32_idx_last_seq", {45'd0, s32.seq, s32.idx}, 64'd0);
    check("x32_last", 64'(s32.last), 64'd1);
    check("x32_addr_count", 64'(addr32_q.size()), 64'd2);
    if (addr32_q.size() == 2) begin
      check("x32_addr_lo", 64'(addr32_q[0]), 64'hB03);
      check("x32_addr_hi", 64'(addr32_q[1]), 64'hB83);
    end

    // Directed: counters 3 and 5 with mask 000101, six busy cycles
    load_bank(0, 64'h10, 64'h2A);
    trig_only(6'b000101, 1'b0);
    wait_idle(bc);
    check("busy_cycles", 64'(bc), 64'd6);
    drain();

    // Back-to-back: second trigger during the walk reads the cleared values
    trig_only(6'b100010, 1'b1);
    repeat (3) tick();
    trig_only(6'b100010, 1'b1);
    wait_idle(bc);
    wait_idle(bc);
    drain();
    bank_match();

    // Randomised walks with random grant and ready
    gnt_mode = 2; rdy_mode = 2;
    for (int it = 0; it < 12; it++) begin
      load_bank(1, 64'd0, 64'd0);
      wait_room();
      trig_only(6'($urandom), 1'($urandom));
      wait_idle(bc);
      bank_match();
    end
    rdy_mode = 1;
    drain();
    check("drop_after_random", 64'(drop), 64'(exp_drop));

    // Grant held low in READ_LO: port stable, nothing captured
    gnt_mode = 0;
    trig_only(6'b000001, 1'b0);
    repeat (4) tick();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!(bus.req === 1'b1 && bus.addr === 12'hB03 && bus.we === 1'b0)) bad = 1;
      tick();
    end
    check("nogrant_port_stable", 64'(bad), 64'd0);
    check("nogrant_no_output", 64'(exp_q.size()), 64'd1);
    gnt_mode = 1;
    wait_idle(bc);
    drain();

    // Debug freeze mid-walk
    trig_only(6'b111111, 1'b0);
    repeat (4) tick();
    debug_mode = 1'b1; tick();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.req !== 1'b0 || busy !== 1'b1) bad = 1;
      tick();
    end
    check("debug_freeze", 64'(bad), 64'd0);
    debug_mode = 1'b0;
    wait_idle(bc);
    drain();

    // FIFO preloaded to 6/8 with ready low: 3-counter snapshot is dropped
    rdy_mode = 0;
    for (int i = 0; i < 6; i++) begin
      trig_only(6'b000001, 1'b0);
      wait_idle(bc);
    end
    acc0 = acc_cnt;
    trig_only(6'b000111, 1'b0);
    wait_idle(bc);
    check("drop_count", 64'(drop), 64'(exp_drop));
    check("drop_expected_one", 64'(exp_drop), 64'd1);
    check("drop_no_port_access", 64'(acc_cnt - acc0), 64'd0);
    rdy_mode = 1;
    drain();

    // Periodic sampling every 100 cycles
    mask = 6'b000001; clear_on_read = 0; interval = 32'd100; enable = 1'b1;
    cyc = 0; rises = 0; prev_rise = 0; pbusy = busy;
    while (rises < 3 && cyc < 400) begin
      tick(); cyc++;
      if (busy && !pbusy) begin
        model_snapshot(6'b000001, 1'b0);
        if (rises > 0) check("period_spacing", 64'(cyc - prev_rise), 64'd100);
        prev_rise = cyc; rises++;
      end
      pbusy = busy;
    end
    enable = 1'b0;
    check("period_rises", 64'(rises), 64'd3);
    repeat (10) tick();
    drain();

    // Asynchronous reset mid-walk with clear-on-read: no further writes
    load_bank(1, 64'd0, 64'd0);
    trig_only(6'b111111, 1'b1);
    repeat (5) tick();
    #2 rst = 1'b1; #1;
    we0 = we_cnt;
    check("rst_mid_req_busy_valid", {61'd0, bus.req, busy, bus.sample_valid}, 64'd0);
    check("rst_mid_we", 64'(bus.we), 64'd0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    check("rst_mid_no_write", 64'(we_cnt - we0), 64'd0);
    check("rst_mid_idle", 64'(busy), 64'd0);
    exp_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
